// File: rtl/biport_pkg.sv
// Shared definitions for the single-wire half-duplex link endpoints.
package biport_pkg;

    localparam int unsigned DATA_BITS = 8;

    // Line levels for framing
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

    typedef enum logic [3:0] {
        StIdle,
        StRxStart,
        StRxData,
        StRxStop,
        StWaitRsp,
        StTurn,
        StTxStart,
        StTxData,
        StTxStop
    } state_e;

endpackage

// File: rtl/biport_sync.sv
// Two-flop synchronizer for the asynchronous line level; resets to the idle level.
module biport_sync
    import biport_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= IDLE_LVL;
            q      <= IDLE_LVL;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/biport_responder.sv
// Responder end of the single-wire link: receive a request byte, wait for a
// local response, turn the line around and drive the response frame back.
module biport_responder
    import biport_pkg::*;
#(
    parameter int unsigned BIT_CYCLES  = 16,
    parameter int unsigned TURN_CYCLES = 8,
    parameter int unsigned RSP_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 data_in,
    output logic                 data_out,
    output logic                 data_en,
    output logic [DATA_BITS-1:0] req_data,
    output logic                 req_valid,
    input  logic [DATA_BITS-1:0] rsp_data,
    input  logic                 rsp_valid,
    output logic                 rsp_ready,
    output logic                 frame_err,
    output logic                 rsp_timeout,
    output logic                 collision,
    output logic                 busy
);

    localparam int unsigned TW  = $clog2(BIT_CYCLES);
    localparam int unsigned WW  = $clog2(RSP_TIMEOUT);
    localparam int unsigned CW  = (TURN_CYCLES > 2) ? $clog2(TURN_CYCLES) : 1;
    localparam int unsigned BW  = $clog2(DATA_BITS);

    // Timer counts down to zero; a load of N-1 gives an N-cycle interval
    localparam logic [TW-1:0] BIT_LOAD  = TW'(BIT_CYCLES - 1);
    localparam logic [TW-1:0] HALF_LOAD = TW'(BIT_CYCLES / 2 - 1);
    // Mid-bit point of a transmitted bit, seen through the synchronizer
    localparam logic [TW-1:0] TX_MID    = TW'(BIT_CYCLES - 1 - BIT_CYCLES / 2);
    localparam logic [WW-1:0] WAIT_LAST = WW'(RSP_TIMEOUT - 1);
    // Handshake cycle counts as the first idle clock before the start bit
    localparam logic [CW-1:0] TURN_LOAD = CW'(TURN_CYCLES - 2);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    state_e               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [WW-1:0]        wait_cnt_q, wait_cnt_d;
    logic [CW-1:0]        turn_cnt_q, turn_cnt_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_BITS-1:0] tx_byte_q, tx_byte_d;
    logic [DATA_BITS-1:0] req_data_q, req_data_d;
    logic                 armed_q, armed_d;
    logic                 req_valid_q, req_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 rsp_timeout_q, rsp_timeout_d;
    logic                 collision_q, collision_d;

    logic rx_s;
    logic timer_done;
    logic tx_active;

    biport_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (data_in),
        .q     (rx_s)
    );

    assign timer_done = (timer_q == '0);
    assign tx_active  = (state_q == StTxStart) || (state_q == StTxData) ||
                        (state_q == StTxStop);

    // Line drive and handshake outputs decoded from the current state
    always_comb begin
        data_en  = tx_active;
        data_out = IDLE_LVL;
        unique case (state_q)
            StTxStart: data_out = START_LVL;
            StTxData:  data_out = tx_byte_q[bit_idx_q];
            StTxStop:  data_out = STOP_LVL;
            default:   data_out = IDLE_LVL;
        endcase
    end

    assign rsp_ready   = (state_q == StWaitRsp);
    assign busy        = (state_q != StIdle);
    assign req_data    = req_data_q;
    assign req_valid   = req_valid_q;
    assign frame_err   = frame_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign collision   = collision_q;

    // Next-state logic for the frame sequencer
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        wait_cnt_d    = wait_cnt_q;
        turn_cnt_d    = turn_cnt_q;
        bit_idx_d     = bit_idx_q;
        rx_shift_d    = rx_shift_q;
        tx_byte_d     = tx_byte_q;
        req_data_d    = req_data_q;
        armed_d       = 1'b0;
        req_valid_d   = 1'b0;
        frame_err_d   = 1'b0;
        rsp_timeout_d = 1'b0;
        collision_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Only a high-to-low transition seen while idle counts as a start
                armed_d = armed_q | (rx_s == IDLE_LVL);
                if (armed_q && (rx_s == START_LVL)) begin
                    state_d = StRxStart;
                    timer_d = HALF_LOAD;
                    armed_d = 1'b0;
                end
            end
            StRxStart: begin
                if (timer_done) begin
                    if (rx_s == START_LVL) begin
                        state_d   = StRxData;
                        timer_d   = BIT_LOAD;
                        bit_idx_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StRxData: begin
                if (timer_done) begin
                    rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
                    timer_d    = BIT_LOAD;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = StRxStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StRxStop: begin
                if (timer_done) begin
                    if (rx_s == STOP_LVL) begin
                        req_data_d  = rx_shift_q;
                        req_valid_d = 1'b1;
                        wait_cnt_d  = '0;
                        state_d     = StWaitRsp;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StIdle;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StWaitRsp: begin
                // Handshake has priority over expiry in the same cycle
                if (rsp_valid) begin
                    tx_byte_d  = rsp_data;
                    turn_cnt_d = TURN_LOAD;
                    state_d    = StTurn;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    rsp_timeout_d = 1'b1;
                    state_d       = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StTurn: begin
                if (turn_cnt_q == '0) begin
                    state_d = StTxStart;
                    timer_d = BIT_LOAD;
                end else begin
                    turn_cnt_d = turn_cnt_q - 1'b1;
                end
            end
            StTxStart: begin
                if (timer_done) begin
                    state_d   = StTxData;
                    timer_d   = BIT_LOAD;
                    bit_idx_d = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StTxData: begin
                if (timer_done) begin
                    timer_d = BIT_LOAD;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = StTxStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StTxStop: begin
                if (timer_done) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Readback check overrides normal sequencing and releases the line
        if (tx_active && (timer_q == TX_MID) && (rx_s != data_out)) begin
            collision_d = 1'b1;
            state_d     = StIdle;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            timer_q       <= '0;
            wait_cnt_q    <= '0;
            turn_cnt_q    <= '0;
            bit_idx_q     <= '0;
            rx_shift_q    <= '0;
            tx_byte_q     <= '0;
            req_data_q    <= '0;
            armed_q       <= 1'b0;
            req_valid_q   <= 1'b0;
            frame_err_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            collision_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            wait_cnt_q    <= wait_cnt_d;
            turn_cnt_q    <= turn_cnt_d;
            bit_idx_q     <= bit_idx_d;
            rx_shift_q    <= rx_shift_d;
            tx_byte_q     <= tx_byte_d;
            req_data_q    <= req_data_d;
            armed_q       <= armed_d;
            req_valid_q   <= req_valid_d;
            frame_err_q   <= frame_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            collision_q   <= collision_d;
        end
    end

endmodule

// File: tb/tb_biport_responder.sv
// Self-checking bench for biport_responder: vector table plus corner-case sequences.
module tb_biport_responder;

    localparam int BC   = 16;
    localparam int TC   = 8;
    localparam int TO   = 1024;
    localparam int RLAT = (19 * BC) / 2 + 3;

    typedef struct {
        logic [7:0] req;
        logic       stop;
        logic       give;
        logic [7:0] rsp;
        int         e_req;
        int         e_ferr;
        int         e_to;
        int         e_tx;
        int         e_rdy;
        int         e_en;
    } vec_t;

    typedef struct {
        int         len;
        logic [9:0] frame;
    } tx_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       data_in, data_out, data_en;
    logic [7:0] req_data, rsp_data;
    logic       req_valid, rsp_valid, rsp_ready;
    logic       frame_err, rsp_timeout, collision, busy;

    // Initiator side of the wire and a fault injector; undriven line floats high
    logic ini_en, ini_bit, force_low;
    assign data_in = force_low ? 1'b0 : (data_en ? data_out : (ini_en ? ini_bit : 1'b1));

    biport_responder #(
        .BIT_CYCLES  (BC),
        .TURN_CYCLES (TC),
        .RSP_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .data_out    (data_out),
        .data_en     (data_en),
        .req_data    (req_data),
        .req_valid   (req_valid),
        .rsp_data    (rsp_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .frame_err   (frame_err),
        .rsp_timeout (rsp_timeout),
        .collision   (collision),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Observations collected by the monitor
    int         tot_req = 0, tot_ferr = 0, tot_to = 0, tot_col = 0;
    int         tot_rdy = 0, tot_en = 0, tot_busy = 0;
    int         t_req = 0, t_to = 0, t_col = 0, t_hs = 0, t_en_rise = 0, t_en_fall = 0;
    int         run = 0;
    logic       en_prev = 1'b0;
    logic [9:0] cap = '0;
    logic [7:0] obs_req[$];
    tx_t        obs_tx[$];

    // Scoreboard expectations, pushed when stimulus is driven
    logic [7:0] exp_req[$];
    logic [9:0] exp_tx[$];
    logic [7:0] exp_last = 8'h00;

    vec_t vecs[5];

    // Monitor: sample outputs on the falling edge, record pulses and TX frames
    always @(negedge clk) begin
        if (req_valid) begin
            tot_req++;
            t_req = cyc;
            obs_req.push_back(req_data);
        end
        if (frame_err) tot_ferr++;
        if (rsp_timeout) begin
            tot_to++;
            t_to = cyc;
        end
        if (collision) begin
            tot_col++;
            t_col = cyc;
        end
        if (rsp_ready) tot_rdy++;
        if (rsp_ready && rsp_valid) t_hs = cyc;
        if (busy) tot_busy++;
        if (data_en) begin
            if (!en_prev) begin
                run = 0;
                cap = '0;
                t_en_rise = cyc;
            end
            if ((run % BC) == (BC / 2) && (run / BC) < 10) cap[run / BC] = data_out;
            run++;
            tot_en++;
        end else if (en_prev) begin
            t_en_fall = cyc;
            obs_tx.push_back('{len: run, frame: cap});
        end
        en_prev = data_en;
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Drive one frame from the initiator side; t0 is the cycle the start bit goes out
    task automatic send_frame(input logic [7:0] b, input logic stop, output int t0);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        @(posedge clk);
        #1;
        t0 = cyc;
        ini_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ini_bit = f[i];
            repeat (BC) begin
                @(posedge clk);
                #1;
            end
        end
        ini_en  = 1'b0;
        ini_bit = 1'b1;
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk({name, "/idle_in_time"}, int'(busy), 0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   s_req, s_ferr, s_to, s_col, s_rdy, s_en, t0;
        tx_t  tx;
        s_req  = tot_req;
        s_ferr = tot_ferr;
        s_to   = tot_to;
        s_col  = tot_col;
        s_rdy  = tot_rdy;
        s_en   = tot_en;
        rsp_data  = v.rsp;
        rsp_valid = v.give;
        if (v.e_req != 0) exp_req.push_back(v.req);
        if (v.e_tx != 0) exp_tx.push_back({1'b1, v.rsp, 1'b0});
        send_frame(v.req, v.stop, t0);
        wait_idle(4000, tag);
        repeat (4) @(negedge clk);
        rsp_valid = 1'b0;

        chk({tag, "/n_req_valid"}, tot_req - s_req, v.e_req);
        chk({tag, "/n_frame_err"}, tot_ferr - s_ferr, v.e_ferr);
        chk({tag, "/n_rsp_timeout"}, tot_to - s_to, v.e_to);
        chk({tag, "/n_collision"}, tot_col - s_col, 0);
        chk({tag, "/rsp_ready_cycles"}, tot_rdy - s_rdy, v.e_rdy);
        chk({tag, "/driven_cycles"}, tot_en - s_en, v.e_en);
        chk({tag, "/n_tx_frames"}, obs_tx.size(), v.e_tx);

        if (v.e_req != 0) begin
            chk({tag, "/req_latency"}, t_req - t0, RLAT);
            exp_last = v.req;
            if (obs_req.size() > 0 && exp_req.size() > 0)
                chk({tag, "/req_data"}, int'(obs_req.pop_front()), int'(exp_req.pop_front()));
        end
        chk({tag, "/req_data_held"}, int'(req_data), int'(exp_last));
        if (v.e_to != 0) chk({tag, "/timeout_delay"}, t_to - t_req, TO);
        if (v.e_tx != 0) begin
            chk({tag, "/turnaround"}, t_en_rise - t_hs, TC);
            if (obs_tx.size() > 0 && exp_tx.size() > 0) begin
                tx = obs_tx.pop_front();
                chk({tag, "/tx_len"}, tx.len, 10 * BC);
                chk({tag, "/tx_frame"}, int'(tx.frame), int'(exp_tx.pop_front()));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s_busy, s_req, s_ferr, s_to, s_col, r, n, t0;
        tx_t tx;
        vec_t v;

        vecs[0] = '{req: 8'hA5, stop: 1'b1, give: 1'b1, rsp: 8'h3C, e_req: 1, e_ferr: 0,
                    e_to: 0, e_tx: 1, e_rdy: 1, e_en: 10 * BC};
        vecs[1] = '{req: 8'h81, stop: 1'b0, give: 1'b1, rsp: 8'h55, e_req: 0, e_ferr: 1,
                    e_to: 0, e_tx: 0, e_rdy: 0, e_en: 0};
        vecs[2] = '{req: 8'h5A, stop: 1'b1, give: 1'b0, rsp: 8'h00, e_req: 1, e_ferr: 0,
                    e_to: 1, e_tx: 0, e_rdy: TO, e_en: 0};
        vecs[3] = '{req: 8'h00, stop: 1'b1, give: 1'b1, rsp: 8'hFF, e_req: 1, e_ferr: 0,
                    e_to: 0, e_tx: 1, e_rdy: 1, e_en: 10 * BC};
        vecs[4] = '{req: 8'hFF, stop: 1'b1, give: 1'b1, rsp: 8'h80, e_req: 1, e_ferr: 0,
                    e_to: 0, e_tx: 1, e_rdy: 1, e_en: 10 * BC};

        rst_n     = 1'b0;
        ini_en    = 1'b0;
        ini_bit   = 1'b1;
        force_low = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset/data_en", int'(data_en), 0);
        chk("reset/data_out", int'(data_out), 1);
        chk("reset/req_data", int'(req_data), 0);
        chk("reset/pulses", int'({req_valid, frame_err, rsp_timeout, collision}), 0);
        chk("reset/rsp_ready", int'(rsp_ready), 0);
        chk("reset/busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Table-driven frames
        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // False start: line low for 4 clocks only
        s_busy = tot_busy;
        s_req  = tot_req;
        s_ferr = tot_ferr;
        @(posedge clk);
        #1;
        ini_en  = 1'b1;
        ini_bit = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        ini_bit = 1'b1;
        ini_en  = 1'b0;
        repeat (30) @(negedge clk);
        chk("false_start/busy_cycles", tot_busy - s_busy, BC / 2);
        chk("false_start/flags", (tot_req - s_req) + (tot_ferr - s_ferr), 0);
        chk("false_start/busy_now", int'(busy), 0);

        // Collision: response 0xFF with the line forced low during data bit 2
        s_col = tot_col;
        s_req = tot_req;
        rsp_data  = 8'hFF;
        rsp_valid = 1'b1;
        exp_req.push_back(8'h42);
        send_frame(8'h42, 1'b1, t0);
        n = 0;
        while (!data_en && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("collision/tx_started", int'(data_en), 1);
        r = cyc;
        repeat (3 * BC) @(negedge clk);
        force_low = 1'b1;
        wait_idle(200, "collision");
        force_low = 1'b0;
        rsp_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("collision/n_pulses", tot_col - s_col, 1);
        chk("collision/pulse_time", t_col - r, 3 * BC + BC / 2 + 1);
        chk("collision/release_time", t_en_fall, t_col);
        chk("collision/no_restart", int'(busy), 0);
        if (obs_tx.size() > 0) begin
            tx = obs_tx.pop_front();
            chk("collision/driven_len", tx.len, 3 * BC + BC / 2 + 1);
        end else begin
            chk("collision/driven_present", 0, 1);
        end
        chk("collision/n_req", tot_req - s_req, 1);
        if (obs_req.size() > 0 && exp_req.size() > 0)
            chk("collision/req_data", int'(obs_req.pop_front()), int'(exp_req.pop_front()));
        exp_last = 8'h42;

        // Reset asserted while driving data bits
        s_to = tot_to;
        rsp_data  = 8'h77;
        rsp_valid = 1'b1;
        send_frame(8'h99, 1'b1, t0);
        n = 0;
        while (!data_en && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid/tx_started", int'(data_en), 1);
        repeat (2 * BC + 8) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid/data_en_async", int'(data_en), 0);
        chk("rst_mid/data_out", int'(data_out), 1);
        chk("rst_mid/req_data", int'(req_data), 0);
        chk("rst_mid/busy", int'(busy), 0);
        rsp_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid/pulses", int'({req_valid, frame_err, rsp_timeout, collision}), 0);
        obs_tx.delete();
        obs_req.delete();
        exp_req.delete();
        exp_last = 8'h00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        chk("rst_mid/no_timeout", tot_to - s_to, 0);

        v = '{req: 8'h11, stop: 1'b1, give: 1'b1, rsp: 8'h22, e_req: 1, e_ferr: 0,
              e_to: 0, e_tx: 1, e_rdy: 1, e_en: 10 * BC};
        run_vec(v, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/biport_responder.md
# biport_responder

Responder end of the single-wire half-duplex link carried over a `biport_wrapper` tri-state pad. It receives a one-byte request frame from the initiator on the shared line and hands the byte to local logic. It then waits for a response byte, turns the line around and drives the response frame back. It finally releases the line. It sits between local logic and one `biport_wrapper` instance, connecting to that wrapper's `data_en`/`data_out`/`data_in`.

## Interface
- `BIT_CYCLES`, 16: clocks per bit; even, ≥4.
- `TURN_CYCLES`, 8: idle clocks between request stop-bit sample and first driven response bit.
- `RSP_TIMEOUT`, 1024: max clocks spent in WAIT_RSP.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `data_in`  in  1  line level from wrapper; asynchronous; reads 1 when undriven.
- `data_out`  out  1  level to drive when `data_en`=1.
- `data_en`  out  1  tri-state enable to wrapper; 1 = responder drives line.
- `req_data`  out  8  last received request byte; valid with `req_valid`.
- `req_valid`  out  1  one-cycle pulse: good request received.
- `rsp_data`  in  8  response byte.
- `rsp_valid`  in  1  response offered.
- `rsp_ready`  out  1  high throughout WAIT_RSP; transfer on `rsp_valid & rsp_ready`.
- `frame_err`  out  1  one-cycle pulse: request stop bit sampled 0.
- `rsp_timeout`  out  1  one-cycle pulse: WAIT_RSP expired.
- `collision`  out  1  one-cycle pulse: line readback mismatch while driving.
- `busy`  out  1  state ≠ IDLE.

## Operation
- Frame: start 0, 8 data bits LSB first, stop 1; each bit held `BIT_CYCLES` clocks.
- `data_in` passes through a 2-flop synchronizer; all sampling uses the synchronized value `rx_s`.
- States: IDLE, RX_START, RX_DATA, RX_STOP, WAIT_RSP, TURN, TX_START, TX_DATA, TX_STOP.
- IDLE: when `rx_s` falls 1→0, go to RX_START and load the bit timer with `BIT_CYCLES/2`.
- RX_START: at timer expiry sample `rx_s`. If 1 it is a false start: return to IDLE with no flags. If 0, go to RX_DATA.
- RX_DATA: sample once per `BIT_CYCLES` (mid-bit) and shift into the byte LSB first. After 8 samples, go to RX_STOP.
- RX_STOP: mid-bit sample. If 1: `req_data` ← byte, `req_valid` pulse, go to WAIT_RSP. If 0: `frame_err` pulse, `req_data` unchanged, go to IDLE.
- WAIT_RSP: `rsp_ready`=1.
  - On handshake: latch `rsp_data` and go to TURN.
  - After `RSP_TIMEOUT` clocks with no handshake: `rsp_timeout` pulse, go to IDLE.
  - A handshake in the expiry cycle wins.
- TURN: `data_en`=0 for `TURN_CYCLES` clocks, then go to TX_START.
- TX_START/TX_DATA/TX_STOP:
  - `data_en`=1 throughout.
  - `data_out` = 0, then the latched bits LSB first, then 1; each bit held `BIT_CYCLES` clocks.
  - After the stop bit, `data_en`=0 and go to IDLE.
- Collision check: at each mid-bit of TX (synchronizer delay included), `rx_s` ≠ `data_out` ⇒ `collision` pulse, `data_en`=0 next clock, go to IDLE.
- IDLE is re-armed only when `rx_s`=1. A low line on entry is not treated as a start.

## Timing
- Reset values: `data_en`=0, `data_out`=1, `req_data`=0, `req_valid`=0, `rsp_ready`=0, `frame_err`=0, `rsp_timeout`=0, `collision`=0, `busy`=0, state IDLE.
- Reset asserted mid-frame clears everything immediately. `data_en` drops asynchronously, with no partial-frame flags.
- `req_valid` occurs 9.5·`BIT_CYCLES`+3 clocks after the `data_in` falling edge, ±1 for synchronizer phase.
- First driven clock (`data_en`=1, `data_out`=0) comes `TURN_CYCLES` clocks after the handshake cycle.
- The line is driven for exactly 10·`BIT_CYCLES` clocks.
- Pulses `req_valid`, `frame_err`, `rsp_timeout`, `collision` are mutually exclusive per frame and each lasts exactly one clock.
- Bit timer and timeout counter widths are `$clog2` of the parameter. The timeout counter must not wrap.

## Structure
- Package `biport_pkg` holds:
  - state enum;
  - `DATA_BITS`=8, `START_LVL`=0, `STOP_LVL`=1, `IDLE_LVL`=1.
- Sub-module `biport_sync`: 2-flop synchronizer with async active-low reset to `IDLE_LVL`, reused by the future initiator.

## Test plan
- Request 0xA5, `rsp_valid` with 0x3C held high → `req_data`=0xA5 pulse. Line then driven 0 | 0,0,1,1,1,1,0,0 | 1 for 160 clocks, then released.
- Line low for 4 clocks then high → no flags, `busy` back to 0 after 8 clocks.
- Request 0x81 with stop bit 0 → `frame_err` pulse, no `req_valid`, `rsp_ready` stays 0.
- Good request, `rsp_valid` never asserted → `rsp_timeout` pulse 1024 clocks after `req_valid`, `data_en` never 1.
- Response 0xFF with the bench forcing `data_in`=0 during data bit 2 → `collision` pulse, `data_en`=0 next clock, IDLE.
- `rst_n` pulled low during TX_DATA → `data_en`=0 in the same cycle. After release a fresh request 0x11 is received correctly.
